// File: rtl/spi_des_framer.sv
// Command framer between an SPI slave byte interface and a DES core.
// Decodes command bytes, assembles 64-bit payloads, launches DES operations and streams results back.
module spi_des_framer #(
    parameter int         SYNC_STAGES  = 2,
    parameter logic [7:0] CMD_ERR_BYTE = 8'hEE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs,
    input  logic [7:0]  recdata,
    input  logic        recflag,
    input  logic        senflag,
    output logic [7:0]  sendata,
    output logic        des_start,
    output logic        des_decrypt,
    output logic [63:0] des_key,
    output logic [63:0] des_din,
    input  logic [63:0] des_dout,
    input  logic        des_done,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        PAYLOAD,
        WAIT,
        READ,
        DISCARD
    } state_t;

    localparam logic [1:0] OP_DEC = 2'd2;
    localparam logic [1:0] OP_KEY = 2'd3;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] cs_sync, rec_sync, sen_sync;
    logic                   cs_prev, rec_prev, sen_prev;
    logic                   cs_s, rec_s, sen_s;
    logic                   cs_rise, cs_fall, byte_ev, send_ev;

    logic [2:0]  cnt;
    logic [3:0]  rd_cnt;
    logic [3:0]  ptr;
    logic [1:0]  op;
    logic        rd_ok;
    logic        result_valid;
    logic [63:0] result;
    logic [55:0] sh;
    logic [63:0] payload;
    logic [7:0]  res_byte;
    logic [7:0]  status;

    logic cmd_xfer, cmd_read, cmd_bad;
    logic payload_byte, payload_last, start_op;
    logic wait_byte, read_byte, read_last, read_send;

    // Synchronizers; a depth of at least 2 is assumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync  <= '1;
            rec_sync <= '0;
            sen_sync <= '0;
            cs_prev  <= 1'b1;
            rec_prev <= 1'b0;
            sen_prev <= 1'b0;
        end else begin
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs};
            rec_sync <= {rec_sync[SYNC_STAGES-2:0], recflag};
            sen_sync <= {sen_sync[SYNC_STAGES-2:0], senflag};
            cs_prev  <= cs_s;
            rec_prev <= rec_s;
            sen_prev <= sen_s;
        end
    end

    assign cs_s    = cs_sync[SYNC_STAGES-1];
    assign rec_s   = rec_sync[SYNC_STAGES-1];
    assign sen_s   = sen_sync[SYNC_STAGES-1];
    assign cs_rise = cs_s & ~cs_prev;
    assign cs_fall = ~cs_s & cs_prev;
    assign byte_ev = rec_s & ~rec_prev;
    assign send_ev = sen_s & ~sen_prev;

    assign payload  = {sh, recdata};
    assign start_op = payload_last && (op != OP_KEY);
    assign status   = {busy, result_valid, err, 5'b0};

    always_comb begin
        res_byte = 8'h00;
        case (ptr[2:0])
            3'd0: res_byte = result[63:56];
            3'd1: res_byte = result[55:48];
            3'd2: res_byte = result[47:40];
            3'd3: res_byte = result[39:32];
            3'd4: res_byte = result[31:24];
            3'd5: res_byte = result[23:16];
            3'd6: res_byte = result[15:8];
            default: res_byte = result[7:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Chip-select edges override whatever the current state would do.
    always_comb begin
        state_next   = state;
        cmd_xfer     = 1'b0;
        cmd_read     = 1'b0;
        cmd_bad      = 1'b0;
        payload_byte = 1'b0;
        payload_last = 1'b0;
        wait_byte    = 1'b0;
        read_byte    = 1'b0;
        read_last    = 1'b0;
        read_send    = 1'b0;
        if (cs_rise) begin
            state_next = IDLE;
        end else if (cs_fall) begin
            state_next = CMD;
        end else begin
            case (state)
                CMD: begin
                    if (byte_ev) begin
                        case (recdata)
                            8'h01, 8'h02, 8'h03: begin
                                cmd_xfer   = 1'b1;
                                state_next = PAYLOAD;
                            end
                            8'h04: begin
                                cmd_read   = 1'b1;
                                state_next = READ;
                            end
                            default: begin
                                cmd_bad    = 1'b1;
                                state_next = DISCARD;
                            end
                        endcase
                    end
                end
                PAYLOAD: begin
                    if (byte_ev) begin
                        payload_byte = 1'b1;
                        if (cnt == 3'd7) begin
                            payload_last = 1'b1;
                            state_next   = (op == OP_KEY) ? CMD : WAIT;
                        end
                    end
                end
                WAIT: begin
                    wait_byte = byte_ev;
                    if (des_done) begin
                        state_next = CMD;
                    end
                end
                READ: begin
                    read_send = send_ev;
                    if (byte_ev) begin
                        read_byte = 1'b1;
                        if (rd_cnt == 4'd8) begin
                            read_last  = 1'b1;
                            state_next = CMD;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            rd_cnt       <= '0;
            ptr          <= '0;
            op           <= '0;
            rd_ok        <= 1'b0;
            err          <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
            des_start    <= 1'b0;
            des_decrypt  <= 1'b0;
            des_key      <= '0;
            des_din      <= '0;
            sendata      <= 8'h00;
        end else begin
            des_start <= start_op;

            if (cs_rise || cs_fall) begin
                cnt    <= '0;
                rd_cnt <= '0;
                ptr    <= '0;
            end else begin
                if (cmd_xfer) begin
                    cnt <= '0;
                end else if (payload_byte) begin
                    cnt <= cnt + 3'd1;
                end
                if (cmd_read) begin
                    rd_cnt <= '0;
                    ptr    <= '0;
                end else begin
                    if (read_byte) begin
                        rd_cnt <= rd_cnt + 4'd1;
                    end
                    if (read_send && !ptr[3]) begin
                        ptr <= ptr + 4'd1;
                    end
                end
            end

            if (cmd_xfer) begin
                op <= recdata[1:0];
            end
            if (cmd_read) begin
                rd_ok <= result_valid;
            end

            if (cmd_bad || wait_byte || (cmd_read && !result_valid)) begin
                err <= 1'b1;
            end else if (cmd_xfer || cmd_read) begin
                err <= 1'b0;
            end

            if (payload_last) begin
                if (op == OP_KEY) begin
                    des_key <= payload;
                end else begin
                    des_din     <= payload;
                    des_decrypt <= (op == OP_DEC);
                end
            end

            // A new launch takes precedence over a stray completion pulse.
            if (start_op) begin
                busy <= 1'b1;
            end else if (des_done) begin
                busy <= 1'b0;
            end

            if (des_done) begin
                result       <= des_dout;
                result_valid <= 1'b1;
            end else if (read_last) begin
                result_valid <= 1'b0;
            end

            if (state == READ) begin
                if (read_send) begin
                    sendata <= (ptr[3] || !rd_ok) ? 8'h00 : res_byte;
                end
            end else if (state == DISCARD) begin
                sendata <= CMD_ERR_BYTE;
            end else begin
                sendata <= status;
            end
        end
    end

    // Only the first seven payload bytes need storing; the eighth is taken straight from recdata.
    always_ff @(posedge clk) begin
        if (payload_byte) begin
            sh <= {sh[47:0], recdata};
        end
    end

endmodule

// File: tb/tb_spi_des_framer.sv
// Bench for spi_des_framer: transaction-level protocol model compared every settled cycle,
// plus literal expectations for key load, encrypt, readback, errors, abort and reset.
module tb_spi_des_framer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b1;
    logic [7:0]  recdata = 8'h00;
    logic        recflag = 1'b0;
    logic        senflag = 1'b0;
    logic [7:0]  sendata;
    logic        des_start;
    logic        des_decrypt;
    logic [63:0] des_key;
    logic [63:0] des_din;
    logic [63:0] des_dout = 64'h0;
    logic        des_done = 1'b0;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    spi_des_framer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs         (cs),
        .recdata    (recdata),
        .recflag    (recflag),
        .senflag    (senflag),
        .sendata    (sendata),
        .des_start  (des_start),
        .des_decrypt(des_decrypt),
        .des_key    (des_key),
        .des_din    (des_din),
        .des_dout   (des_dout),
        .des_done   (des_done),
        .busy       (busy),
        .err        (err)
    );

    int   n_chk = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;
    int   start_seen = 0;
    bit   start_prev = 1'b0;
    logic [7:0] last_miso;

    // Protocol model: mode 0 idle, 1 command, 2 payload, 3 waiting, 4 reading, 5 discarding
    int          m_mode = 0;
    int          m_op = 0;
    int          m_nbytes = 0;
    int          m_rdn = 0;
    int          m_ptr = 0;
    int          m_starts = 0;
    logic [63:0] m_sh = 64'h0;
    logic [63:0] m_key = 64'h0;
    logic [63:0] m_din = 64'h0;
    logic        m_dec = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_err = 1'b0;
    logic        m_rv = 1'b0;
    logic        m_rd_ok = 1'b0;
    logic [63:0] m_result = 64'h0;
    logic [7:0]  m_rd_data = 8'h00;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_status();
        return {m_busy, m_rv, m_err, 5'b0};
    endfunction

    function automatic logic [7:0] exp_send();
        if (m_mode == 5) return 8'hEE;
        if (m_mode == 4) return m_rd_data;
        return m_status();
    endfunction

    task automatic model_byte(input logic [7:0] b);
        case (m_mode)
            1: begin
                if (b >= 8'h01 && b <= 8'h03) begin
                    m_err = 1'b0;
                    m_op = int'(b);
                    m_nbytes = 0;
                    m_mode = 2;
                end else if (b == 8'h04) begin
                    m_rd_data = m_status();
                    m_err = !m_rv;
                    m_rd_ok = m_rv;
                    m_ptr = 0;
                    m_rdn = 0;
                    m_mode = 4;
                end else begin
                    m_err = 1'b1;
                    m_mode = 5;
                end
            end
            2: begin
                m_sh = {m_sh[55:0], b};
                m_nbytes++;
                if (m_nbytes == 8) begin
                    if (m_op == 3) begin
                        m_key = m_sh;
                        m_mode = 1;
                    end else begin
                        m_din = m_sh;
                        m_dec = (m_op == 2);
                        m_busy = 1'b1;
                        m_starts++;
                        m_mode = 3;
                    end
                end
            end
            3: m_err = 1'b1;
            4: begin
                m_rdn++;
                if (m_rdn == 9) begin
                    m_mode = 1;
                    m_rv = 1'b0;
                end
            end
            default: ;
        endcase
    endtask

    task automatic model_send();
        logic [63:0] t;
        if (m_mode == 4) begin
            t = m_result >> (56 - 8 * m_ptr);
            m_rd_data = (m_ptr < 8 && m_rd_ok) ? t[7:0] : 8'h00;
            if (m_ptr < 8) m_ptr++;
        end
    endtask

    task automatic model_done(input logic [63:0] v);
        m_result = v;
        m_busy = 1'b0;
        m_rv = 1'b1;
        if (m_mode == 3) m_mode = 1;
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_key = 64'h0;
        m_din = 64'h0;
        m_dec = 1'b0;
        m_busy = 1'b0;
        m_err = 1'b0;
        m_rv = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One SPI byte slot: byte received, then the slave asks for the next byte to shift out.
    task automatic xfer(input logic [7:0] b);
        chk_en = 1'b0;
        recdata = b;
        recflag = 1'b1;
        tick(4);
        recflag = 1'b0;
        tick(2);
        model_byte(b);
        senflag = 1'b1;
        tick(4);
        model_send();
        last_miso = sendata;
        chk_en = 1'b1;
        senflag = 1'b0;
        tick(2);
    endtask

    task automatic send_payload(input logic [63:0] v);
        for (int i = 0; i < 8; i++) xfer(v[63 - 8 * i -: 8]);
    endtask

    task automatic set_cs(input logic v);
        chk_en = 1'b0;
        cs = v;
        tick(5);
        if (v) m_mode = 0;
        else m_mode = 1;
        chk_en = 1'b1;
    endtask

    task automatic do_done(input logic [63:0] v);
        chk_en = 1'b0;
        des_dout = v;
        des_done = 1'b1;
        tick(1);
        des_done = 1'b0;
        tick(2);
        model_done(v);
        chk_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (des_start) begin
            start_seen++;
            check("des_start_single_cycle", start_prev, 1'b0);
        end
        start_prev = des_start;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("sendata", sendata, exp_send());
            check("busy", busy, m_busy);
            check("err", err, m_err);
            check("des_key", des_key, m_key);
            check("des_din", des_din, m_din);
            check("des_decrypt", des_decrypt, m_dec);
            check("start_count", start_seen, m_starts);
        end
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    logic [7:0] rb [10];
    logic [7:0] exp_rb [10] = '{8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00};

    initial begin
        tick(3);
        check("rst_sendata", sendata, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_key", des_key, 64'h0);
        check("rst_din", des_din, 64'h0);
        check("rst_start", des_start, 1'b0);
        rst_n = 1'b1;
        tick(3);
        chk_en = 1'b1;

        set_cs(1'b0);
        xfer(8'h03);
        send_payload(64'h0102030405060708);
        check("key_load", des_key, 64'h0102030405060708);
        check("key_no_start", start_seen, 0);

        xfer(8'h01);
        send_payload(64'h1122334455667788);
        check("enc_din", des_din, 64'h1122334455667788);
        check("enc_decrypt", des_decrypt, 1'b0);
        check("enc_start", start_seen, 1);
        check("enc_busy_status", sendata, 8'h80);
        tick(5);
        do_done(64'hCAFEF00DDEADBEEF);
        check("done_status", sendata, 8'h40);

        xfer(8'h04);
        rb[0] = last_miso;
        for (int i = 1; i <= 9; i++) begin
            xfer(8'h00);
            rb[i] = last_miso;
        end
        for (int i = 0; i < 10; i++) check($sformatf("readback_slot%0d", i + 2), rb[i], exp_rb[i]);
        check("readback_rv_cleared", sendata, 8'h00);

        xfer(8'h04);
        rb[0] = last_miso;
        for (int i = 1; i <= 9; i++) begin
            xfer(8'hFF);
            rb[i] = last_miso;
        end
        for (int i = 0; i < 9; i++) check($sformatf("empty_read_slot%0d", i + 2), rb[i], 8'h00);
        check("empty_read_err_status", rb[9], 8'h20);
        check("empty_read_err", err, 1'b1);
        set_cs(1'b1);
        check("idle_err_status", sendata, 8'h20);

        set_cs(1'b0);
        xfer(8'h7F);
        check("bad_cmd_err", err, 1'b1);
        check("bad_cmd_sendata", sendata, 8'hEE);
        xfer(8'h55);
        check("discard_sendata", sendata, 8'hEE);
        set_cs(1'b1);
        set_cs(1'b0);
        xfer(8'h03);
        check("err_cleared", err, 1'b0);
        send_payload(64'h8877665544332211);
        check("key_reload", des_key, 64'h8877665544332211);

        xfer(8'h02);
        for (int i = 0; i < 4; i++) xfer(8'hA0 + 8'(i));
        set_cs(1'b1);
        check("abort_no_start", start_seen, 1);
        check("abort_key_kept", des_key, 64'h8877665544332211);
        check("abort_busy", busy, 1'b0);

        set_cs(1'b0);
        xfer(8'h02);
        send_payload(64'h0123456789ABCDEF);
        check("dec_din", des_din, 64'h0123456789ABCDEF);
        check("dec_decrypt", des_decrypt, 1'b1);
        check("dec_start", start_seen, 2);
        xfer(8'h99);
        check("wait_byte_err", err, 1'b1);
        check("wait_byte_busy", busy, 1'b1);
        check("wait_byte_din", des_din, 64'h0123456789ABCDEF);
        check("wait_byte_status", sendata, 8'hA0);

        chk_en = 1'b0;
        rst_n = 1'b0;
        cs = 1'b1;
        #1;
        check("midwait_rst_busy", busy, 1'b0);
        check("midwait_rst_sendata", sendata, 8'h00);
        check("midwait_rst_start", des_start, 1'b0);
        tick(1);
        des_dout = 64'h1234567812345678;
        des_done = 1'b1;
        tick(1);
        des_done = 1'b0;
        tick(1);
        rst_n = 1'b1;
        model_reset();
        tick(3);
        chk_en = 1'b1;
        check("post_rst_status", sendata, 8'h00);
        check("post_rst_key", des_key, 64'h0);

        set_cs(1'b0);
        xfer(8'h03);
        send_payload(64'h0F1E2D3C4B5A6978);
        check("post_rst_key_load", des_key, 64'h0F1E2D3C4B5A6978);
        set_cs(1'b1);
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
